// File: rtl/vga_dither_out.sv
// Final VGA pixel stage: 8->4 bit per channel reduction with 2x2 ordered dither,
// optional frame-alternating matrix shift, and a matched 2-cycle delay on the qualifiers.
module vga_dither_out #(
    parameter logic SYNC_POL = 1'b0,
    parameter int   TEMPORAL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pixel_in,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        dither_en,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out
);

    // Position / frame tracking
    logic x0_reg;
    logic y0_reg;
    logic frame_reg;
    logic prev_de_reg;
    logic prev_vs_reg;

    logic vs_active;
    logic vs_start;
    logic de_fall;
    logic shift_bit;
    logic [3:0] thr_next;

    assign vs_active = (vsync_in == SYNC_POL);
    assign vs_start  = vs_active & ~prev_vs_reg;
    assign de_fall   = prev_de_reg & ~de_in;
    assign shift_bit = (TEMPORAL != 0) ? frame_reg : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_reg      <= 1'b0;
            y0_reg      <= 1'b0;
            frame_reg   <= 1'b0;
            prev_de_reg <= 1'b0;
            prev_vs_reg <= 1'b0;
        end else begin
            prev_de_reg <= de_in;
            prev_vs_reg <= vs_active;
            // A vsync start overrides a coincident end-of-line.
            if (vs_start) begin
                x0_reg    <= 1'b0;
                y0_reg    <= 1'b0;
                frame_reg <= ~frame_reg;
            end else if (de_fall) begin
                x0_reg <= 1'b0;
                y0_reg <= ~y0_reg;
            end else if (de_in) begin
                x0_reg <= ~x0_reg;
            end
        end
    end

    // Threshold uses the position before this cycle's update.
    always_comb begin
        thr_next = 4'd0;
        case ({y0_reg ^ shift_bit, x0_reg ^ shift_bit})
            2'b00:   thr_next = 4'd0;
            2'b01:   thr_next = 4'd8;
            2'b10:   thr_next = 4'd12;
            default: thr_next = 4'd4;
        endcase
    end

    // Stage 1
    logic [23:0] pix_s1_reg;
    logic        de_s1_reg;
    logic        hs_s1_reg;
    logic        vs_s1_reg;
    logic        en_s1_reg;
    logic [3:0]  thr_s1_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_s1_reg <= 24'd0;
            de_s1_reg  <= 1'b0;
            hs_s1_reg  <= ~SYNC_POL;
            vs_s1_reg  <= ~SYNC_POL;
            en_s1_reg  <= 1'b0;
            thr_s1_reg <= 4'd0;
        end else begin
            pix_s1_reg <= pixel_in;
            de_s1_reg  <= de_in;
            hs_s1_reg  <= hsync_in;
            vs_s1_reg  <= vsync_in;
            en_s1_reg  <= dither_en;
            thr_s1_reg <= thr_next;
        end
    end

    // Stage 2: per-channel saturating dither add, blanked outside active video
    logic [11:0] rgb_next;

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [7:0] chan;
        logic [8:0] sum;
        logic [3:0] dith;
        assign chan = pix_s1_reg[gi*8 +: 8];
        assign sum  = {1'b0, chan} + {5'b0, thr_s1_reg};
        assign dith = sum[8] ? 4'hF : sum[7:4];
        assign rgb_next[gi*4 +: 4] = !de_s1_reg ? 4'h0 :
                                     (en_s1_reg ? dith : chan[7:4]);
    end

    logic [11:0] rgb_reg;
    logic        de_s2_reg;
    logic        hs_s2_reg;
    logic        vs_s2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_reg   <= 12'd0;
            de_s2_reg <= 1'b0;
            hs_s2_reg <= ~SYNC_POL;
            vs_s2_reg <= ~SYNC_POL;
        end else begin
            rgb_reg   <= rgb_next;
            de_s2_reg <= de_s1_reg;
            hs_s2_reg <= hs_s1_reg;
            vs_s2_reg <= vs_s1_reg;
        end
    end

    assign vga_r     = rgb_reg[3:0];
    assign vga_g     = rgb_reg[7:4];
    assign vga_b     = rgb_reg[11:8];
    assign de_out    = de_s2_reg;
    assign hsync_out = hs_s2_reg;
    assign vsync_out = vs_s2_reg;

endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out: one instance per TEMPORAL setting, both checked every
// cycle against a line/column/frame-counting reference model, plus directed literals.
module tb_vga_dither_out;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] pixel_in = 24'hFFFFFF;
    logic        de_in = 1'b1;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        dither_en = 1'b1;
    int          lit_s_in = -1;
    int          lit_t_in = -1;

    logic [3:0] r_t, g_t, b_t, r_s, g_s, b_s;
    logic       hs_t, vs_t, de_t, hs_s, vs_s, de_s;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    vga_dither_out #(.SYNC_POL(1'b0), .TEMPORAL(1)) dut_t (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .dither_en(dither_en),
        .vga_r(r_t), .vga_g(g_t), .vga_b(b_t),
        .hsync_out(hs_t), .vsync_out(vs_t), .de_out(de_t)
    );

    vga_dither_out #(.SYNC_POL(1'b0), .TEMPORAL(0)) dut_s (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .dither_en(dither_en),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
        .hsync_out(hs_s), .vsync_out(vs_s), .de_out(de_s)
    );

    task automatic chk(input string nm, input int act, input int expv);
        total_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    endtask

    // Reference model
    typedef struct {
        logic [11:0] rgb_t;
        logic [11:0] rgb_s;
        logic        hs;
        logic        vs;
        logic        de;
        int          lit_s;
        int          lit_t;
    } exp_t;

    int bayer [2][2] = '{'{0, 8}, '{12, 4}};   // [row parity][column parity]

    function automatic exp_t rst_exp();
        exp_t e;
        e.rgb_t = 12'd0; e.rgb_s = 12'd0;
        e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
        e.lit_s = -1; e.lit_t = -1;
        return e;
    endfunction

    function automatic logic [11:0] expect_rgb(input logic [23:0] p, input logic d,
                                               input logic en, input int thr);
        logic [11:0] res;
        res = 12'd0;
        for (int ch = 0; ch < 3; ch++) begin
            int c;
            int v;
            c = int'(p[8*ch +: 8]);
            if (!d)      v = 0;
            else if (en) v = ((c + thr > 255) ? 255 : c + thr) / 16;
            else         v = c / 16;
            res[4*ch +: 4] = v[3:0];
        end
        return res;
    endfunction

    exp_t p1 = rst_exp();
    exp_t p2 = rst_exp();
    int   col = 0, row = 0, frame = 0;
    logic prev_de = 1'b0, prev_vsa = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            col = 0; row = 0; frame = 0;
            prev_de = 1'b0; prev_vsa = 1'b0;
            p1 = rst_exp();
            p2 = rst_exp();
        end else begin
            logic vsa;
            p2 = p1;
            p1.de = de_in; p1.hs = hsync_in; p1.vs = vsync_in;
            p1.lit_s = lit_s_in; p1.lit_t = lit_t_in;
            p1.rgb_s = expect_rgb(pixel_in, de_in, dither_en, bayer[row % 2][col % 2]);
            p1.rgb_t = expect_rgb(pixel_in, de_in, dither_en,
                                  bayer[(row + frame) % 2][(col + frame) % 2]);
            vsa = (vsync_in == 1'b0);
            if (vsa && !prev_vsa) begin
                col = 0; row = 0; frame++;
            end else if (prev_de && !de_in) begin
                col = 0; row++;
            end else if (de_in) begin
                col++;
            end
            prev_de = de_in;
            prev_vsa = vsa;
        end
    end

    // Per-cycle compare, away from the active edge
    always @(negedge clk) begin
        chk("rgb_t", int'({b_t, g_t, r_t}), int'(p2.rgb_t));
        chk("rgb_s", int'({b_s, g_s, r_s}), int'(p2.rgb_s));
        chk("de_t", int'(de_t), int'(p2.de));
        chk("de_s", int'(de_s), int'(p2.de));
        chk("hs_t", int'(hs_t), int'(p2.hs));
        chk("hs_s", int'(hs_s), int'(p2.hs));
        chk("vs_t", int'(vs_t), int'(p2.vs));
        chk("vs_s", int'(vs_s), int'(p2.vs));
        if (p2.lit_s >= 0) chk("lit_r_s", int'(r_s), p2.lit_s);
        if (p2.lit_t >= 0) chk("lit_r_t", int'(r_t), p2.lit_t);
    end

    task automatic step(input logic [23:0] p, input logic d, input logic h, input logic v,
                        input logic en, input int ls, input int lt);
        @(posedge clk);
        #1;
        pixel_in = p; de_in = d; hsync_in = h; vsync_in = v; dither_en = en;
        lit_s_in = ls; lit_t_in = lt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(24'h0, 1'b0, 1'b1, 1'b1, 1'b1, -1, -1);
    endtask

    task automatic vsync_pulse();
        step(24'h0, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1);
        idle(2);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_r", int'(r_s), 0);
        chk("reset_gb", int'({g_t, b_t}), 0);
        chk("reset_de", int'(de_s), 0);
        chk("reset_hs", int'(hs_t), 1);
        chk("reset_vs", int'(vs_s), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // Ramp: frame 1 (odd); static matrix gives 7,8 / 8,8, shifted matrix 8,8 / 8,7
        vsync_pulse();
        step(24'h00007C, 1'b1, 1'b1, 1'b1, 1'b1, 7, 8);
        step(24'h00007C, 1'b1, 1'b1, 1'b1, 1'b1, 8, 8);
        idle(2);
        step(24'h00007C, 1'b1, 1'b1, 1'b1, 1'b1, 8, 8);
        step(24'h00007C, 1'b1, 1'b1, 1'b1, 1'b1, 8, 7);
        idle(2);

        // Temporal: frame 2 (even) then frame 3 (odd) at origin
        vsync_pulse();
        step(24'h00007C, 1'b1, 1'b1, 1'b1, 1'b1, 7, 7);
        idle(2);
        vsync_pulse();
        step(24'h00007C, 1'b1, 1'b1, 1'b1, 1'b1, 7, 8);
        idle(2);

        // Saturation / truncation at row 1, column 0 (thr 12 in the static matrix)
        vsync_pulse();
        step(24'h123456, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
        step(24'h123456, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
        idle(1);
        step(24'hFAFAFA, 1'b1, 1'b1, 1'b1, 1'b1, 15, -1);
        step(24'hFAFAFA, 1'b1, 1'b1, 1'b1, 1'b0, 15, -1);
        step(24'h7C7C7C, 1'b1, 1'b1, 1'b1, 1'b0, 7, 7);
        idle(2);

        // Edge collision: de falls in the vsync-start cycle (frame 5, odd)
        step(24'h00007C, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
        step(24'h00007C, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
        step(24'h0, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1);
        idle(2);
        step(24'h00007C, 1'b1, 1'b1, 1'b1, 1'b1, 7, 8);
        idle(2);

        // Randomized traffic with a mid-line reset
        for (int i = 0; i < 3000; i++) begin
            logic d;
            d = de_in;
            if ($urandom_range(0, 7) == 0) d = ~d;
            step(24'($urandom), d,
                 ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1,
                 1'($urandom_range(0, 1)), -1, -1);
            if (i == 1500) begin
                de_in = 1'b1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        end
        idle(4);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
